// File: rtl/pc_branch_ctrl_pkg.sv
// pc_pkg: shared definitions for the program-counter / branch-resolution block.
//   F3_*        branch funct3 encodings (instr[14:12])
//   pc_state_e  control-flow trap state: RUN, TRAP (handler running), HALT (double fault)
package pc_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      TRAP = 2'd1,
      HALT = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_branch_ctrl_br_decide.sv
// br_decide: pure combinational branch-condition decode.
// Ports:
//   i_funct3   branch funct3
//   i_less     comparator less result (signedness chosen upstream via funct3[1])
//   i_equal    comparator equal result
//   o_taken    branch condition satisfied
//   o_illegal  funct3 is 010/011 (no such branch); never taken
module br_decide
   import pc_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_less,
   input  logic       i_equal,
   output logic       o_taken,
   output logic       o_illegal
);

   always_comb begin
      o_taken   = 1'b0;
      o_illegal = 1'b0;
      case (i_funct3)
         F3_BEQ:           o_taken = i_equal;
         F3_BNE:           o_taken = ~i_equal;
         F3_BLT, F3_BLTU:  o_taken = i_less;
         F3_BGE, F3_BGEU:  o_taken = ~i_less;
         default:          o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: program counter register and branch/jump resolution with
// misaligned-target trap handling (RUN -> TRAP -> RUN, double fault -> HALT).
// Optional macro PC_BRANCH_STATS_EN adds o_br_total / o_br_taken counters.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_stall                  freeze all registered state this cycle
//   i_is_branch/jal/jalr     instruction type strobes (jalr > jal > branch)
//   i_funct3, i_imm          instr[14:12], sign-extended immediate
//   i_rs1_data               JALR base
//   i_br_less, i_br_equal    comparator results
//   i_trap_ack               handler acknowledges pending trap
//   o_br_un                  comparator unsigned select
//   o_pc, o_pc_four          current PC, PC+4
//   o_taken, o_illegal       combinational control-transfer decision / bad branch funct3
//   o_trap, o_mepc, o_halted trap pending, faulting PC, double-fault freeze
module pc_branch_ctrl
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_is_branch,
   input  logic        i_is_jal,
   input  logic        i_is_jalr,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_imm,
   input  logic [31:0] i_rs1_data,
   input  logic        i_br_less,
   input  logic        i_br_equal,
   input  logic        i_trap_ack,
   output logic        o_br_un,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_four,
   output logic        o_taken,
   output logic        o_illegal,
   output logic        o_trap,
   output logic [31:0] o_mepc,
   output logic        o_halted
`ifdef PC_BRANCH_STATS_EN
   ,
   output logic [31:0] o_br_total,
   output logic [31:0] o_br_taken
`endif
);

   pc_state_e   r_state, w_state_nxt;
   logic [31:0] r_pc, r_mepc;
   logic [31:0] w_pc_nxt, w_mepc_nxt;
   logic [31:0] w_target, w_seq, w_next;
   logic        w_sel_jalr, w_sel_jal, w_sel_br;
   logic        w_br_taken, w_br_illegal, w_misaligned;

   br_decide u_br_decide (
      .i_funct3  (i_funct3),
      .i_less    (i_br_less),
      .i_equal   (i_br_equal),
      .o_taken   (w_br_taken),
      .o_illegal (w_br_illegal)
   );

   // One-hot selection honouring jalr > jal > branch.
   assign w_sel_jalr = i_is_jalr;
   assign w_sel_jal  = i_is_jal & ~i_is_jalr;
   assign w_sel_br   = i_is_branch & ~i_is_jal & ~i_is_jalr;

   assign w_target     = w_sel_jalr ? ((i_rs1_data + i_imm) & ~32'h1) : (r_pc + i_imm);
   assign w_seq        = r_pc + 32'd4;
   assign o_taken      = w_sel_jalr | w_sel_jal | (w_sel_br & w_br_taken);
   assign o_illegal    = w_sel_br & w_br_illegal;
   assign w_next       = o_taken ? w_target : w_seq;
   assign w_misaligned = o_taken & w_target[1];

   assign o_br_un   = i_funct3[1];
   assign o_pc      = r_pc;
   assign o_pc_four = w_seq;
   assign o_mepc    = r_mepc;
   assign o_trap    = (r_state == TRAP);
   assign o_halted  = (r_state == HALT);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_mepc_nxt  = r_mepc;
      if (!i_stall) begin
         case (r_state)
            RUN: begin
               if (w_misaligned) begin
                  w_pc_nxt    = TRAP_VECTOR;
                  w_mepc_nxt  = r_pc;
                  w_state_nxt = TRAP;
               end else begin
                  w_pc_nxt = w_next;
               end
            end
            TRAP: begin
               if (i_trap_ack) begin
                  // Ack clears the old trap first; a fault in the same cycle re-traps.
                  if (w_misaligned) begin
                     w_pc_nxt   = TRAP_VECTOR;
                     w_mepc_nxt = r_pc;
                  end else begin
                     w_pc_nxt    = w_next;
                     w_state_nxt = RUN;
                  end
               end else if (w_misaligned) begin
                  w_state_nxt = HALT;
               end else begin
                  w_pc_nxt = w_next;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RUN;
         r_pc    <= RESET_VECTOR;
         r_mepc  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_mepc  <= w_mepc_nxt;
      end
   end

`ifdef PC_BRANCH_STATS_EN
   logic [31:0] r_br_total, r_br_taken;
   logic        w_cnt_en;

   assign w_cnt_en   = ~i_stall & (r_state != HALT);
   assign o_br_total = r_br_total;
   assign o_br_taken = r_br_taken;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_br_total <= '0;
         r_br_taken <= '0;
      end else if (w_cnt_en) begin
         if (i_is_branch)              r_br_total <= r_br_total + 32'd1;
         if (i_is_branch & w_br_taken) r_br_taken <= r_br_taken + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
module tb_pc_branch_ctrl;

   logic        clk, rst_n, stall, is_br, is_jal, is_jalr, less, equal, ack;
   logic [2:0]  f3;
   logic [31:0] imm, rs1;
   logic        br_un, taken, illegal, trap, halted;
   logic [31:0] pc, pc_four, mepc;
`ifdef PC_BRANCH_STATS_EN
   logic [31:0] br_total, br_taken;
`endif

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   pc_branch_ctrl #(.RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
      .i_is_branch(is_br), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
      .i_funct3(f3), .i_imm(imm), .i_rs1_data(rs1),
      .i_br_less(less), .i_br_equal(equal), .i_trap_ack(ack),
      .o_br_un(br_un), .o_pc(pc), .o_pc_four(pc_four), .o_taken(taken),
      .o_illegal(illegal), .o_trap(trap), .o_mepc(mepc), .o_halted(halted)
`ifdef PC_BRANCH_STATS_EN
      , .o_br_total(br_total), .o_br_taken(br_taken)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one instruction's inputs and let combinational outputs settle.
   task automatic drive(input logic b, input logic j, input logic jr, input logic [2:0] fn,
                        input logic [31:0] im, input logic [31:0] r1, input logic ls,
                        input logic eq, input logic ak, input logic st);
      is_br = b; is_jal = j; is_jalr = jr; f3 = fn; imm = im; rs1 = r1;
      less = ls; equal = eq; ack = ak; stall = st;
      #1;
   endtask

   // Clock once, then park in an idle stalled state so nothing else moves.
   task automatic tick();
      @(posedge clk);
      #1;
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 1);
   endtask

   task automatic test_reset();
      n_total += 4;
      if (pc !== 32'h0)   $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0);       else n_pass++;
      if (mepc !== 32'h0) $display("FAIL reset_mepc got=%h exp=%h", mepc, 32'h0);   else n_pass++;
      if (trap !== 1'b0)  $display("FAIL reset_trap got=%b exp=0", trap);           else n_pass++;
      if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted);      else n_pass++;
   endtask

   task automatic test_wrap();
      drive(0, 1, 0, 3'b000, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0);
      tick();
      n_total += 2;
      if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got=%h exp=%h", pc, 32'hFFFF_FFFC); else n_pass++;
      if (pc_four !== 32'h0)    $display("FAIL wrap_pc_four got=%h exp=%h", pc_four, 32'h0); else n_pass++;
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 0);
      tick();
      n_total++;
      if (pc !== 32'h0) $display("FAIL wrap_seq_pc got=%h exp=%h", pc, 32'h0); else n_pass++;
   endtask

   task automatic test_branches();
      drive(0, 1, 0, 3'b000, 32'h40, 32'h0, 0, 0, 0, 0);
      tick();
      n_total++;
      if (pc !== 32'h40) $display("FAIL jal_pc got=%h exp=%h", pc, 32'h40); else n_pass++;
      // BEQ taken
      drive(1, 0, 0, 3'b000, 32'h10, 32'h0, 0, 1, 0, 0);
      n_total += 4;
      if (taken !== 1'b1)        $display("FAIL beq_taken got=%b exp=1", taken);                else n_pass++;
      if (br_un !== 1'b0)        $display("FAIL beq_br_un got=%b exp=0", br_un);                else n_pass++;
      if (pc_four !== 32'h44)    $display("FAIL beq_pc_four got=%h exp=%h", pc_four, 32'h44);   else n_pass++;
      if (illegal !== 1'b0)      $display("FAIL beq_illegal got=%b exp=0", illegal);            else n_pass++;
      tick();
      n_total++;
      if (pc !== 32'h50) $display("FAIL beq_pc got=%h exp=%h", pc, 32'h50); else n_pass++;
      // BLTU not taken
      drive(1, 0, 0, 3'b110, 32'h20, 32'h0, 0, 0, 0, 0);
      n_total += 2;
      if (br_un !== 1'b1) $display("FAIL bltu_br_un got=%b exp=1", br_un); else n_pass++;
      if (taken !== 1'b0) $display("FAIL bltu_taken got=%b exp=0", taken); else n_pass++;
      tick();
      n_total++;
      if (pc !== 32'h54) $display("FAIL bltu_pc got=%h exp=%h", pc, 32'h54); else n_pass++;
      // BGE taken (less=0)
      drive(1, 0, 0, 3'b101, 32'h8, 32'h0, 0, 0, 0, 0);
      n_total++;
      if (taken !== 1'b1) $display("FAIL bge_taken got=%b exp=1", taken); else n_pass++;
      tick();
      n_total++;
      if (pc !== 32'h5C) $display("FAIL bge_pc got=%h exp=%h", pc, 32'h5C); else n_pass++;
      // BNE not taken (equal=1)
      drive(1, 0, 0, 3'b001, 32'h8, 32'h0, 0, 1, 0, 0);
      n_total++;
      if (taken !== 1'b0) $display("FAIL bne_taken got=%b exp=0", taken); else n_pass++;
      tick();
      n_total++;
      if (pc !== 32'h60) $display("FAIL bne_pc got=%h exp=%h", pc, 32'h60); else n_pass++;
   endtask

   task automatic test_illegal();
      drive(1, 0, 0, 3'b010, 32'h40, 32'h0, 1, 1, 0, 0);
      n_total += 2;
      if (illegal !== 1'b1) $display("FAIL illegal_flag got=%b exp=1", illegal); else n_pass++;
      if (taken !== 1'b0)   $display("FAIL illegal_taken got=%b exp=0", taken);  else n_pass++;
      tick();
      n_total++;
      if (pc !== 32'h64) $display("FAIL illegal_pc got=%h exp=%h", pc, 32'h64); else n_pass++;
   endtask

   task automatic test_stall();
      drive(0, 1, 0, 3'b000, 32'h100, 32'h0, 0, 0, 0, 1);
      n_total++;
      if (taken !== 1'b1) $display("FAIL stall_taken got=%b exp=1", taken); else n_pass++;
      tick();
      n_total++;
      if (pc !== 32'h64) $display("FAIL stall_pc got=%h exp=%h", pc, 32'h64); else n_pass++;
   endtask

   task automatic test_priority();
      // jalr wins: (0x201+4)&~1 = 0x204; jal would give 0x68
      drive(1, 1, 1, 3'b000, 32'h4, 32'h201, 0, 0, 0, 0);
      tick();
      n_total += 2;
      if (pc !== 32'h204) $display("FAIL prio_pc got=%h exp=%h", pc, 32'h204); else n_pass++;
      if (trap !== 1'b0)  $display("FAIL prio_trap got=%b exp=0", trap);       else n_pass++;
   endtask

   task automatic test_trap();
      drive(0, 0, 1, 3'b000, 32'h0, 32'h1003, 0, 0, 0, 0);
      tick();
      n_total += 3;
      if (pc !== 32'h100)   $display("FAIL trap_pc got=%h exp=%h", pc, 32'h100);     else n_pass++;
      if (trap !== 1'b1)    $display("FAIL trap_flag got=%b exp=1", trap);           else n_pass++;
      if (mepc !== 32'h204) $display("FAIL trap_mepc got=%h exp=%h", mepc, 32'h204); else n_pass++;
      // Stalled ack must not be consumed
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 1, 1);
      tick();
      n_total += 2;
      if (trap !== 1'b1)  $display("FAIL stall_ack_trap got=%b exp=1", trap);      else n_pass++;
      if (pc !== 32'h100) $display("FAIL stall_ack_pc got=%h exp=%h", pc, 32'h100); else n_pass++;
      // Handler advances
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 0);
      tick();
      n_total++;
      if (pc !== 32'h104) $display("FAIL handler_pc got=%h exp=%h", pc, 32'h104); else n_pass++;
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 1, 0);
      tick();
      n_total += 2;
      if (trap !== 1'b0)  $display("FAIL ack_trap got=%b exp=0", trap);        else n_pass++;
      if (pc !== 32'h108) $display("FAIL ack_pc got=%h exp=%h", pc, 32'h108); else n_pass++;
   endtask

   task automatic test_ack_and_fault();
      drive(0, 1, 0, 3'b000, 32'h2, 32'h0, 0, 0, 0, 0);   // 0x10A misaligned
      tick();
      n_total += 2;
      if (trap !== 1'b1)    $display("FAIL jal_fault_trap got=%b exp=1", trap);           else n_pass++;
      if (mepc !== 32'h108) $display("FAIL jal_fault_mepc got=%h exp=%h", mepc, 32'h108); else n_pass++;
      drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0, 0);
      tick();
      drive(0, 1, 0, 3'b000, 32'h6, 32'h0, 0, 0, 1, 0);   // 0x104+6=0x10A, with ack
      tick();
      n_total += 4;
      if (trap !== 1'b1)    $display("FAIL ackfault_trap got=%b exp=1", trap);           else n_pass++;
      if (halted !== 1'b0)  $display("FAIL ackfault_halted got=%b exp=0", halted);       else n_pass++;
      if (mepc !== 32'h104) $display("FAIL ackfault_mepc got=%h exp=%h", mepc, 32'h104); else n_pass++;
      if (pc !== 32'h100)   $display("FAIL ackfault_pc got=%h exp=%h", pc, 32'h100);     else n_pass++;
   endtask

   task automatic test_halt();
      drive(1, 0, 0, 3'b000, 32'h12, 32'h0, 0, 1, 0, 0);  // 0x112 misaligned, no ack
      tick();
      n_total += 3;
      if (halted !== 1'b1)  $display("FAIL halt_flag got=%b exp=1", halted);          else n_pass++;
      if (pc !== 32'h100)   $display("FAIL halt_pc got=%h exp=%h", pc, 32'h100);      else n_pass++;
      if (mepc !== 32'h104) $display("FAIL halt_mepc got=%h exp=%h", mepc, 32'h104);  else n_pass++;
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 0, 3'b000, 32'h8, 32'h0, 0, 0, i[0], 0);
         tick();
         n_total += 2;
         if (pc !== 32'h100)  $display("FAIL halt_frozen_pc[%0d] got=%h exp=%h", i, pc, 32'h100); else n_pass++;
         if (halted !== 1'b1) $display("FAIL halt_frozen_flag[%0d] got=%b exp=1", i, halted);    else n_pass++;
      end
      rst_n = 1'b0;
      #2;
      n_total += 4;
      if (pc !== 32'h0)    $display("FAIL rst_halt_pc got=%h exp=%h", pc, 32'h0);     else n_pass++;
      if (halted !== 1'b0) $display("FAIL rst_halt_halted got=%b exp=0", halted);     else n_pass++;
      if (trap !== 1'b0)   $display("FAIL rst_halt_trap got=%b exp=0", trap);         else n_pass++;
      if (mepc !== 32'h0)  $display("FAIL rst_halt_mepc got=%h exp=%h", mepc, 32'h0); else n_pass++;
      rst_n = 1'b1;
   endtask

`ifdef PC_BRANCH_STATS_EN
   task automatic test_stats();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 3'b000, 32'h8, 32'h0, 0, 1, 0, 0);   // BEQ taken
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 3'b001, 32'h8, 32'h0, 0, 1, 0, 0);   // BNE not taken
         tick();
      end
      drive(1, 0, 0, 3'b000, 32'h8, 32'h0, 0, 1, 0, 1);      // stalled, excluded
      tick();
      n_total += 2;
      if (br_total !== 32'd5) $display("FAIL stats_total got=%0d exp=5", br_total); else n_pass++;
      if (br_taken !== 32'd3) $display("FAIL stats_taken got=%0d exp=3", br_taken); else n_pass++;
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      is_br = 0; is_jal = 0; is_jalr = 0; f3 = '0; imm = '0; rs1 = '0;
      less = 0; equal = 0; ack = 0; stall = 1;
      #12;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_wrap();
      test_branches();
      test_illegal();
      test_stall();
      test_priority();
      test_trap();
      test_ack_and_fault();
      test_halt();
`ifdef PC_BRANCH_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
